// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard definitions: forward-select encodings, Tuse sentinel, MD latencies.
// Also the per-source stall and forward-select helpers used by hazard_ctrl.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic src_stall(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] ex_wr,
        input logic [1:0] ex_tnew,
        input logic [4:0] mem_wr,
        input logic [1:0] mem_tnew
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (addr == ex_wr)  && (ex_tnew > tuse);
        mem_hit = (addr == mem_wr) && (mem_tnew > tuse);
        return (addr != 5'd0) && (tuse != TUSE_NONE) && (ex_hit || mem_hit);
    endfunction

    // Newest producer wins; a not-yet-ready newest match must not fall
    // through to an older, stale copy of the same register.
    function automatic fwd_sel_e fwd_sel(
        input logic [4:0] addr,
        input logic [4:0] ex_wr,
        input logic [1:0] ex_tnew,
        input logic [4:0] mem_wr,
        input logic [1:0] mem_tnew,
        input logic [4:0] wb_wr
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        if (addr == 5'd0) begin
            sel = FWD_RF;
        end else if (addr == ex_wr) begin
            sel = (ex_tnew == 2'd0) ? FWD_EX : FWD_RF;
        end else if (addr == mem_wr) begin
            sel = (mem_tnew == 2'd0) ? FWD_MEM : FWD_RF;
        end else if (addr == wb_wr) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy-window counter: loads the unit latency on an idle issue,
// then counts down; busy is high while the count is nonzero.
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i && cnt_q == 4'd0) begin
            cnt_d = is_div_i ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall detection, ID forward selects, MD hold.
// Define HAZARD_STATS_EN to add the saturating stall_count output.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic [1:0] id_rs_tuse,
    input  logic [1:0] id_rt_tuse,
    input  logic       id_uses_md,
    input  logic [4:0] ex_wr_addr,
    input  logic [1:0] ex_tnew,
    input  logic [4:0] mem_wr_addr,
    input  logic [1:0] mem_tnew,
    input  logic [4:0] wb_wr_addr,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       stall_pc,
    output logic       stall_if_id,
    output logic       clr_id_ex,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    logic rs_stall;
    logic rt_stall;
    logic md_stall;
    logic stall;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md (
        .clk     (clk),
        .reset   (reset),
        .start_i (md_start),
        .is_div_i(md_is_div),
        .busy_o  (md_busy)
    );

    assign rs_stall = src_stall(id_rs_addr, id_rs_tuse, ex_wr_addr,
                                ex_tnew, mem_wr_addr, mem_tnew);
    assign rt_stall = src_stall(id_rt_addr, id_rt_tuse, ex_wr_addr,
                                ex_tnew, mem_wr_addr, mem_tnew);
    // md_start covers the issue cycle, before the counter has loaded
    assign md_stall = id_uses_md && (md_busy || md_start);
    assign stall    = rs_stall || rt_stall || md_stall;

    assign stall_pc    = stall;
    assign stall_if_id = stall;
    assign clr_id_ex   = stall;

    assign fwd_rs_sel = fwd_sel(id_rs_addr, ex_wr_addr, ex_tnew,
                                mem_wr_addr, mem_tnew, wb_wr_addr);
    assign fwd_rt_sel = fwd_sel(id_rt_addr, ex_wr_addr, ex_tnew,
                                mem_wr_addr, mem_tnew, wb_wr_addr);

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Define HAZARD_STATS_EN to also exercise the stall counter.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic [1:0] id_rs_tuse;
    logic [1:0] id_rt_tuse;
    logic       id_uses_md;
    logic [4:0] ex_wr_addr;
    logic [1:0] ex_tnew;
    logic [4:0] mem_wr_addr;
    logic [1:0] mem_tnew;
    logic [4:0] wb_wr_addr;
    logic       md_start;
    logic       md_is_div;
    logic       stall_pc;
    logic       stall_if_id;
    logic       clr_id_ex;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .id_rs_addr (id_rs_addr),
        .id_rt_addr (id_rt_addr),
        .id_rs_tuse (id_rs_tuse),
        .id_rt_tuse (id_rt_tuse),
        .id_uses_md (id_uses_md),
        .ex_wr_addr (ex_wr_addr),
        .ex_tnew    (ex_tnew),
        .mem_wr_addr(mem_wr_addr),
        .mem_tnew   (mem_tnew),
        .wb_wr_addr (wb_wr_addr),
        .md_start   (md_start),
        .md_is_div  (md_is_div),
        .stall_pc   (stall_pc),
        .stall_if_id(stall_if_id),
        .clr_id_ex  (clr_id_ex),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs_addr  = 5'd0;
        id_rt_addr  = 5'd0;
        id_rs_tuse  = 2'd3;
        id_rt_tuse  = 2'd3;
        id_uses_md  = 1'b0;
        ex_wr_addr  = 5'd0;
        ex_tnew     = 2'd0;
        mem_wr_addr = 5'd0;
        mem_tnew    = 2'd0;
        wb_wr_addr  = 5'd0;
        md_start    = 1'b0;
        md_is_div   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_stall(input string name, input logic exp);
        checks++;
        if ({stall_pc, stall_if_id, clr_id_ex} !== {3{exp}}) begin
            errors++;
            $display("FAIL %s: stall_pc/if_id/clr=%b%b%b expected %b%b%b",
                     name, stall_pc, stall_if_id, clr_id_ex, exp, exp, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        id_rs_tuse = 2'd0;
        id_rt_tuse = 2'd0;
        #1;
        chk_stall("reset_stall", 1'b0);
        checks++;
        if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_fwd: rs=%0d rt=%0d expected 0 0",
                     fwd_rs_sel, fwd_rt_sel);
        end
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: md_busy=%b expected 0", md_busy);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: %0d expected 0", stall_count);
        end
`endif
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_rs_addr = 5'd5;
        id_rs_tuse = 2'd1;
        ex_wr_addr = 5'd5;
        ex_tnew    = 2'd2;
        #1;
        chk_stall("load_use_ex", 1'b1);
        ex_wr_addr  = 5'd0;
        ex_tnew     = 2'd0;
        mem_wr_addr = 5'd5;
        mem_tnew    = 2'd1;
        #1;
        chk_stall("load_use_mem", 1'b0);
        mem_tnew = 2'd2;
        #1;
        chk_stall("load_use_mem2", 1'b1);
        mem_wr_addr = 5'd0;
        mem_tnew    = 2'd0;
        wb_wr_addr  = 5'd5;
        #1;
        chk_stall("load_use_wb", 1'b0);
        checks++;
        if (fwd_rs_sel !== 2'd2) begin
            errors++;
            $display("FAIL load_use_fwd: rs_sel=%0d expected 2", fwd_rs_sel);
        end
    endtask

    task automatic test_branch_fwd();
        idle_inputs();
        id_rt_addr  = 5'd8;
        id_rt_tuse  = 2'd0;
        mem_wr_addr = 5'd8;
        mem_tnew    = 2'd0;
        #1;
        chk_stall("branch_mem_stall", 1'b0);
        checks++;
        if (fwd_rt_sel !== 2'd1) begin
            errors++;
            $display("FAIL branch_mem_fwd: rt_sel=%0d expected 1", fwd_rt_sel);
        end
        ex_wr_addr = 5'd8;
        ex_tnew    = 2'd0;
        #1;
        checks++;
        if (fwd_rt_sel !== 2'd3) begin
            errors++;
            $display("FAIL branch_ex_fwd: rt_sel=%0d expected 3", fwd_rt_sel);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        id_rs_addr = 5'd0;
        id_rs_tuse = 2'd0;
        ex_wr_addr = 5'd0;
        ex_tnew    = 2'd2;
        wb_wr_addr = 5'd0;
        #1;
        chk_stall("zero_stall", 1'b0);
        checks++;
        if (fwd_rs_sel !== 2'd0) begin
            errors++;
            $display("FAIL zero_fwd: rs_sel=%0d expected 0", fwd_rs_sel);
        end
    endtask

    task automatic test_no_stall_match();
        idle_inputs();
        id_rs_addr  = 5'd7;
        id_rs_tuse  = 2'd2;
        ex_wr_addr  = 5'd7;
        ex_tnew     = 2'd2;
        mem_wr_addr = 5'd7;
        mem_tnew    = 2'd0;
        #1;
        chk_stall("late_use_stall", 1'b0);
        checks++;
        if (fwd_rs_sel !== 2'd0) begin
            errors++;
            $display("FAIL late_use_fwd: rs_sel=%0d expected 0", fwd_rs_sel);
        end
        id_rs_addr = 5'd0;
        id_rt_addr = 5'd9;
        id_rt_tuse = 2'd3;
        ex_wr_addr = 5'd9;
        #1;
        chk_stall("tuse_none", 1'b0);
        id_rt_tuse = 2'd1;
        #1;
        chk_stall("rt_ex_stall", 1'b1);
    endtask

    task automatic test_div_busy();
        int busy_n;
        idle_inputs();
        @(negedge clk);
        md_start   = 1'b1;
        md_is_div  = 1'b1;
        id_uses_md = 1'b1;
        #1;
        chk_stall("md_issue_stall", 1'b1);
        @(negedge clk);
        md_start = 1'b0;
        busy_n   = 0;
        for (int i = 0; i < 14; i++) begin
            if (md_busy === 1'b1) busy_n++;
            checks++;
            if (stall_pc !== (i < 10)) begin
                errors++;
                $display("FAIL div_stall[%0d]: stall=%b busy=%b", i, stall_pc, md_busy);
            end
            @(negedge clk);
        end
        checks++;
        if (busy_n != 10) begin
            errors++;
            $display("FAIL div_busy_len: %0d cycles expected 10", busy_n);
        end
        id_uses_md = 1'b0;
    endtask

    task automatic test_md_ignore();
        int busy_n;
        idle_inputs();
        @(negedge clk);
        md_start = 1'b1;
        busy_n   = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            md_start = (i == 2 || i == 5);
            if (md_busy === 1'b1) busy_n++;
        end
        checks++;
        if (busy_n != 5) begin
            errors++;
            $display("FAIL md_ignore_len: %0d cycles expected 5", busy_n);
        end
        md_start = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        int busy_n;
        idle_inputs();
        @(negedge clk);
        md_start  = 1'b1;
        md_is_div = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: md_busy=%b expected 0", md_busy);
        end
        md_start  = 1'b1;
        md_is_div = 1'b0;
        busy_n    = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            md_start = 1'b0;
            if (md_busy === 1'b1) busy_n++;
        end
        checks++;
        if (busy_n != 5) begin
            errors++;
            $display("FAIL mult_after_reset: %0d cycles expected 5", busy_n);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        id_rs_addr = 5'd5;
        id_rs_tuse = 2'd0;
        ex_wr_addr = 5'd5;
        ex_tnew    = 2'd1;
        repeat (7) @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_count !== 32'd7) begin
            errors++;
            $display("FAIL stats_count: %0d expected 7", stall_count);
        end
        dut.stall_cnt_q = 32'hFFFF_FFFD;
        id_rs_addr = 5'd5;
        id_rs_tuse = 2'd0;
        ex_wr_addr = 5'd5;
        ex_tnew    = 2'd1;
        repeat (5) @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stats_sat: %h expected ffffffff", stall_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_fwd();
        test_zero_reg();
        test_no_stall_match();
        test_div_busy();
        test_md_ignore();
        test_reset_mid_div();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
